// File: rtl/varredura_linha_matriz_pkg.sv
// Shared types and defaults for the LED-matrix row scanner.
package varredura_linha_matriz_pkg;

  localparam int N_ROWS_DEF = 7;
  localparam int N_COLS_DEF = 5;
  localparam int CDL_W      = 4;
  localparam int CDC_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic [CDL_W-1:0] row;
    logic [CDC_W-1:0] col;
  } coord_t;

endpackage

// File: rtl/varredura_linha_matriz_if.sv
// Coordinate handshake between a point source and the row scanner.
interface varredura_linha_matriz_if;
  import varredura_linha_matriz_pkg::*;

  logic [CDL_W-1:0] cdl;
  logic [CDC_W-1:0] cdc;
  logic             coord_valid;
  logic             coord_ready;

  modport master (output cdl, cdc, coord_valid, input coord_ready);
  modport slave  (input cdl, cdc, coord_valid, output coord_ready);
endinterface

// File: rtl/divisor_varredura.sv
// Row-slot prescaler: tick is high on the last of every DIV cycles.
module divisor_varredura #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr || tick) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/varredura_linha_matriz.sv
// LED-matrix row scanner: accepts one point via valid/ready and swaps it
// onto the display only at frame boundaries so the image never tears.
module varredura_linha_matriz
  import varredura_linha_matriz_pkg::*;
#(
  parameter int N_ROWS = N_ROWS_DEF,
  parameter int N_COLS = N_COLS_DEF,
  parameter int DIV    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  varredura_linha_matriz_if.slave  coord,
  input  logic                     enable,
  output logic [N_ROWS-1:0]        linhas,
  output logic [N_COLS-1:0]        colunas,
  output logic                     frame_start,
  output logic                     coord_err
);
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);

  state_t        state, state_d;
  logic [RW-1:0] row_idx, row_d;
  coord_t        act, act_d, pend, pend_d, in_pt;
  logic          act_v, act_v_d;
  logic          rdy, rdy_d;
  logic          tick, fb, xfer, legal;
  logic          fs_d, err_d;
  logic [N_ROWS-1:0] linhas_d;
  logic [N_COLS-1:0] colunas_d;

  divisor_varredura #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  assign in_pt = '{row: coord.cdl, col: coord.cdc};
  assign fb    = (state == SCAN) && tick && (row_idx == ROW_LAST);
  assign xfer  = coord.coord_valid && rdy;
  assign legal = !coord.cdl[CDL_W-1] && (coord.cdl < CDL_W'(N_ROWS))
                 && (coord.cdc < CDC_W'(N_COLS));

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d  = state;
    row_d    = row_idx;
    act_d    = act;
    act_v_d  = act_v;
    pend_d   = pend;
    rdy_d    = rdy;
    fs_d     = 1'b0;
    err_d    = 1'b0;

    case (state)
      IDLE: begin
        row_d = '0;
        if (enable) begin
          state_d = SCAN;
          fs_d    = 1'b1;
        end
      end
      SCAN: begin
        if (tick) begin
          if (row_idx == ROW_LAST) begin
            row_d = '0;
            if (enable) fs_d    = 1'b1;
            else        state_d = IDLE;
          end else begin
            row_d = row_idx + RW'(1);
          end
        end
      end
    endcase

    // Commit and transfer are exclusive: a commit needs pending full, a transfer needs it empty.
    if (fb && !rdy) begin
      act_d   = pend;
      act_v_d = 1'b1;
      rdy_d   = 1'b1;
    end

    if (xfer) begin
      if (!legal) begin
        err_d = 1'b1;
      end else if (state == IDLE) begin
        act_d   = in_pt;
        act_v_d = 1'b1;
      end else begin
        pend_d = in_pt;
        rdy_d  = 1'b0;
      end
    end

    // Outputs are decoded from next-state values so they line up with the new state.
    linhas_d  = '1;
    colunas_d = '0;
    if (state_d == SCAN) begin
      linhas_d = ~(N_ROWS'(1) << row_d);
      if (act_v_d && (act_d.row == CDL_W'(row_d)))
        colunas_d = N_COLS'(1) << act_d.col;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_idx     <= '0;
      act_v       <= 1'b0;
      rdy         <= 1'b1;
      linhas      <= '1;
      colunas     <= '0;
      frame_start <= 1'b0;
      coord_err   <= 1'b0;
    end else begin
      state       <= state_d;
      row_idx     <= row_d;
      act_v       <= act_v_d;
      rdy         <= rdy_d;
      linhas      <= linhas_d;
      colunas     <= colunas_d;
      frame_start <= fs_d;
      coord_err   <= err_d;
    end
  end

  // NOTE: point payloads need no reset; they are only observed through act_v / rdy.
  always_ff @(posedge clk) begin
    act  <= act_d;
    pend <= pend_d;
  end

  assign coord.coord_ready = rdy;
endmodule
